// File: rtl/nl_alloc_pkg.sv
// Shared types and helpers for the switch allocator.
// Ports: none (package).
// Provides the per-output lock state enum and the round-robin one-hot pick.
package nl_alloc_pkg;

  typedef enum logic {
    ALLOC_IDLE   = 1'b0,
    ALLOC_LOCKED = 1'b1
  } alloc_state_t;

  // Largest port count the pick helper handles; the allocator's n must not exceed it.
  localparam int ALLOC_NMAX = 32;
  localparam int ALLOC_IW   = 5;

  // One-hot pick of the first set bit at or after ptr, wrapping modulo n.
  // Only bits [n-1:0] of req are considered; the result is zero if none is set.
  function automatic logic [ALLOC_NMAX-1:0] rr_pick(
    input logic [ALLOC_NMAX-1:0] req,
    input int                    ptr,
    input int                    n
  );
    logic [ALLOC_NMAX-1:0] pick;
    logic                  found;
    int                    idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < ALLOC_NMAX; k++) begin
      if (!found && (k < n)) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[ALLOC_IW-1:0]]) begin
          pick[idx[ALLOC_IW-1:0]] = 1'b1;
          found                   = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/nl_rr_arbiter.sv
// Per-output round-robin arbiter with head-to-tail packet lock.
// Latency: zero cycles (select is combinational from state + inputs); state updates on clk.
// Backpressure: out_ready low blocks the grant and freezes state, pointer and owner.
// Ports: req_col (inputs requesting this output), out_ready, req_tail -> sel_row (one-hot or zero).
module nl_rr_arbiter
  import nl_alloc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_col,
  input  logic         out_ready,
  input  logic [N-1:0] req_tail,
  output logic [N-1:0] sel_row
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  alloc_state_t          state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         owner_q, owner_d;
  logic [ALLOC_NMAX-1:0] pick;
  logic [PW-1:0]         win;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    sel_row = '0;
    pick    = rr_pick(ALLOC_NMAX'(req_col), 32'(ptr_q), N);

    // Index of the picked input; the pick is one-hot so at most one bit matches.
    win = '0;
    for (int i = 0; i < ALLOC_NMAX; i++) begin
      if (pick[i]) win = PW'(i);
    end

    // Grants are suppressed for the whole time reset is held, even though the
    // state registers already read IDLE.
    if (rst_n) begin
      unique case (state_q)
        ALLOC_IDLE: begin
          if (out_ready && (|req_col)) begin
            sel_row = pick[N-1:0];
            // Explicit wrap keeps non-power-of-two N correct.
            ptr_d   = (win == PW'(N - 1)) ? '0 : win + PW'(1);
            if (!req_tail[win]) begin
              state_d = ALLOC_LOCKED;
              owner_d = win;
            end
          end
        end
        ALLOC_LOCKED: begin
          // Only the owner may use the output; a missing request is a bubble
          // and the lock is kept. The pointer never moves here.
          if (out_ready && req_col[owner_q]) begin
            sel_row[owner_q] = 1'b1;
            if (req_tail[owner_q]) state_d = ALLOC_IDLE;
          end
        end
        default: state_d = ALLOC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ALLOC_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: rtl/nl_switch_allocator.sv
// Separable single-stage switch allocator feeding the router crossbar.
// Latency: zero cycles, grant/xbar_select valid in the same cycle as req.
// Backpressure: out_ready[o] low withholds output o's grant and holds its state.
// Ports: req[i][o] one-hot per input, req_tail[i], out_ready[o] -> grant[i], xbar_select[o][i].
module nl_switch_allocator
  import nl_alloc_pkg::*;
#(
  parameter int n = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [n-1:0][n-1:0] req,
  input  logic [n-1:0]        req_tail,
  input  logic [n-1:0]        out_ready,
  output logic [n-1:0]        grant,
  output logic [n-1:0][n-1:0] xbar_select
);

  // Per-output view of the requests: req_col[o][i] = req[i][o].
  logic [n-1:0][n-1:0] req_col;

  for (genvar go = 0; go < n; go++) begin : g_out
    for (genvar gi = 0; gi < n; gi++) begin : g_in
      assign req_col[go][gi] = req[gi][go];
    end

    nl_rr_arbiter #(.N(n)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_col   (req_col[go]),
      .out_ready (out_ready[go]),
      .req_tail  (req_tail),
      .sel_row   (xbar_select[go])
    );
  end

  // One-hot requests guarantee each input appears in at most one select row.
  always_comb begin
    grant = '0;
    for (int o = 0; o < n; o++) begin
      grant = grant | xbar_select[o];
    end
  end

  for (genvar gi = 0; gi < n; gi++) begin : g_chk
    a_req_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req[gi]));
  end

endmodule

// File: tb/tb_nl_switch_allocator.sv
// Testbench for nl_switch_allocator (n=4): directed steps plus random traffic,
// checked against a behavioural allocator model.
module tb_nl_switch_allocator;

  logic             clk;
  logic             rst_n;
  logic [3:0][3:0]  req;
  logic [3:0]       req_tail;
  logic [3:0]       out_ready;
  logic [3:0]       grant;
  logic [3:0][3:0]  xbar_select;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state: per output, lock flag, owner and priority pointer.
  bit  m_lock  [4];
  int  m_owner [4];
  int  m_ptr   [4];
  int  m_win   [4];
  logic [3:0]      exp_grant;
  logic [3:0][3:0] exp_sel;

  nl_switch_allocator #(.n(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_tail    (req_tail),
    .out_ready   (out_ready),
    .grant       (grant),
    .xbar_select (xbar_select)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < 4; o++) begin
      m_lock[o]  = 1'b0;
      m_owner[o] = 0;
      m_ptr[o]   = 0;
    end
  endtask

  // Decide this cycle's winner per output from the allocation rules.
  task automatic model_eval();
    exp_grant = '0;
    exp_sel   = '0;
    for (int o = 0; o < 4; o++) begin
      m_win[o] = -1;
      if (rst_n && out_ready[o]) begin
        if (!m_lock[o]) begin
          for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr[o] + k) % 4;
            if (m_win[o] < 0 && req[i][o]) m_win[o] = i;
          end
        end else if (req[m_owner[o]][o]) begin
          m_win[o] = m_owner[o];
        end
      end
      if (m_win[o] >= 0) begin
        exp_sel[o][m_win[o]] = 1'b1;
        exp_grant[m_win[o]]  = 1'b1;
      end
    end
  endtask

  task automatic model_update();
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int o = 0; o < 4; o++) begin
        if (m_win[o] >= 0) begin
          if (!m_lock[o]) begin
            m_ptr[o] = (m_win[o] + 1) % 4;
            if (!req_tail[m_win[o]]) begin
              m_lock[o]  = 1'b1;
              m_owner[o] = m_win[o];
            end
          end else if (req_tail[m_win[o]]) begin
            m_lock[o] = 1'b0;
          end
        end
      end
    end
  endtask

  // One cycle: inputs are already driven (after a negedge). Compare against the
  // model and, when dchk is set, against hand-derived constants too.
  task automatic cyc(input string tag, input bit dchk, input logic [3:0] dg, input logic [15:0] ds);
    #2;
    model_eval();
    chk({tag, ".grant_model"}, 16'(grant), 16'(exp_grant));
    chk({tag, ".sel_model"}, xbar_select, exp_sel);
    if (dchk) begin
      chk({tag, ".grant"}, 16'(grant), 16'(dg));
      chk({tag, ".sel"}, xbar_select, ds);
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    req_tail  = '0;
    out_ready = 4'hF;
    model_reset();
    @(negedge clk);

    // 1. Reset: nothing granted, even with requests present while held.
    cyc("rst_idle", 1'b1, 4'h0, 16'h0000);
    req[0] = 4'b0001;
    req_tail = 4'b0001;
    cyc("rst_req", 1'b1, 4'h0, 16'h0000);
    rst_n = 1'b1;
    req   = '0;
    cyc("post_rst", 1'b1, 4'h0, 16'h0000);

    // 2. Three single-flit streams into output 3: rotation 0,1,2,0,1,2.
    req[0] = 4'b1000;
    req[1] = 4'b1000;
    req[2] = 4'b1000;
    req_tail = 4'b0111;
    for (int c = 0; c < 6; c++) begin
      logic [3:0] oh;
      oh = 4'(1 << (c % 3));
      cyc("rr_out3", 1'b1, oh, {oh, 12'h000});
    end

    // 3. Input 1 sends 3 flits to output 2 while input 3 also asks for it.
    req = '0;
    req[1] = 4'b0100;
    req[3] = 4'b0100;
    req_tail = 4'b1000;
    cyc("pkt_head", 1'b1, 4'b0010, 16'h0200);
    cyc("pkt_body", 1'b1, 4'b0010, 16'h0200);
    req_tail = 4'b1010;
    cyc("pkt_tail", 1'b1, 4'b0010, 16'h0200);
    req[1] = 4'b0000;
    cyc("pkt_next", 1'b1, 4'b1000, 16'h0800);

    // 4. Lock held through two not-ready cycles and an owner bubble.
    req[1] = 4'b0100;
    req_tail = 4'b1000;
    cyc("bp_head", 1'b1, 4'b0010, 16'h0200);
    out_ready = 4'b1011;
    cyc("bp_stall0", 1'b1, 4'b0000, 16'h0000);
    cyc("bp_stall1", 1'b1, 4'b0000, 16'h0000);
    out_ready = 4'hF;
    cyc("bp_resume", 1'b1, 4'b0010, 16'h0200);
    req[1] = 4'b0000;
    cyc("bp_bubble", 1'b1, 4'b0000, 16'h0000);
    req[1] = 4'b0100;
    req_tail = 4'b1010;
    cyc("bp_tail", 1'b1, 4'b0010, 16'h0200);
    req[1] = 4'b0000;
    cyc("bp_next", 1'b1, 4'b1000, 16'h0800);

    // 5. Four non-conflicting requests all granted in parallel.
    req[0] = 4'b0100;
    req[1] = 4'b1000;
    req[2] = 4'b0001;
    req[3] = 4'b0010;
    req_tail = 4'hF;
    cyc("parallel", 1'b1, 4'hF, 16'h2184);

    // 6. Reset while output 0 is locked to input 2; no stale lock afterwards.
    req = '0;
    req[2] = 4'b0001;
    req_tail = 4'b0000;
    cyc("lock_o0", 1'b1, 4'b0100, 16'h0004);
    rst_n = 1'b0;
    model_reset();
    cyc("mid_rst", 1'b1, 4'b0000, 16'h0000);
    rst_n = 1'b1;
    req[2] = 4'b0000;
    req[3] = 4'b0001;
    req_tail = 4'b1000;
    cyc("after_rst", 1'b1, 4'b1000, 16'h0008);

    // Random traffic with sticky requests so multi-flit locks form and break.
    req = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          int r;
          r = int'($urandom_range(0, 5));
          req[i] = (r < 4) ? 4'(1 << r) : 4'b0000;
        end
      end
      req_tail  = 4'($urandom_range(0, 15));
      out_ready = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      cyc("random", 1'b0, 4'h0, 16'h0000);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/nl_switch_allocator.md
Name: nl_switch_allocator

Overview:
- Per-cycle switch allocator sitting directly upstream of the router crossbar.
- Each input presents a one-hot output request. The block arbitrates per output using round-robin priority.
- It drives the crossbar's one-hot select matrix and returns a per-input grant.
- Outputs stay locked to one input from head flit to tail flit, so packets are never interleaved.

Parameters:
- n, 4, number of router ports; the same value as the crossbar it feeds.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  [n-1:0][n-1:0]  req[i][o]=1: input i requests output o; at most one bit set per i.
- req_tail  input  [n-1:0]  flit at input i is a packet tail (single-flit packets are head+tail).
- out_ready  input  [n-1:0]  output o can accept a flit this cycle (downstream credit available).
- grant  output  [n-1:0]  grant[i]=1: input i's flit traverses the crossbar this cycle.
- xbar_select  output  [n-1:0][n-1:0]  xbar_select[o][i]=1: output o takes input i; each row is one-hot or zero.

Behaviour:
- Reset is asynchronous and active-low, on rst_n. All outputs are combinational from registered state plus inputs, so there is no separate output reset value.
  - During and immediately after reset: every output is IDLE and every priority pointer is 0.
  - With req=0, grant=0 and xbar_select=0.
- Latency: allocation takes zero cycles. Grant and select are valid in the same cycle as req. State updates on the rising clk edge.
- Per-output state machine, one per output o:
  - IDLE: candidates are all i with req[i][o]=1.
  - If out_ready[o]=1 and there is at least one candidate, grant the first candidate at or after ptr[o], searching i = ptr, ptr+1, ... with wrap-around mod n.
    - Set xbar_select[o][i]=1.
    - ptr[o] <= (i+1) mod n.
    - If req_tail[i]=0: go to LOCKED with owner[o] <= i. Otherwise stay IDLE.
  - LOCKED: only owner[o] is eligible; all other requests for o are ignored.
    - If req[owner][o]=1 and out_ready[o]=1: grant owner. If req_tail[owner]=1, go to IDLE.
    - Otherwise: no grant, stay LOCKED.
    - The pointer does not move while LOCKED.
- out_ready[o]=0 in either state: no grant for o, and no state or pointer change.
- grant[i] = OR over o of xbar_select[o][i]. Because requests are one-hot per input, each input has at most one grant.
- Each input's requested output is evaluated independently, so allocation is single-stage and separable. No input can win two outputs.
- Illegal stimulus: multi-hot req[i]. A simulation assertion flags it; the resulting RTL behaviour is undefined.
- Reset asserted mid-packet:
  - Locks are cleared immediately (asynchronously) and pointers return to 0.
  - No grants while rst_n=0.
- An owner dropping its request while LOCKED (bubble) keeps the lock.
- Width rules: ptr and owner are each $clog2(n) bits, minimum 1. Wrap is explicit mod n, so non-power-of-two n is supported.

Decomposition:
- Shared package nl_alloc_pkg:
  - alloc_state_t enum {ALLOC_IDLE, ALLOC_LOCKED}.
  - Function for round-robin one-hot pick from a request vector and a pointer.
- Sub-module nl_rr_arbiter, instantiated n times in a generate loop, one per output. It holds the state, ptr and owner registers.
  - Inputs: the request column for its output, out_ready bit, req_tail.
  - Output: one xbar_select row.
- Top level:
  - Transposes req into per-output columns.
  - ORs the select rows into grant.
  - Holds the one-hot request assertion.

Test Plan (n=4):
1. Reset, then req=0 -> grant=0, xbar_select all zero, all outputs IDLE.
2. Inputs 0, 1, 2 each send a single-flit packet (tail=1) to output 3 every cycle, out_ready=4'hF -> grants rotate 0, 1, 2, 0, 1, 2; xbar_select[3] = 0001, 0010, 0100, 0001.
3. Input 1 sends 3-flit packet to output 2 (tail on third), input 3 also requests output 2 throughout -> input 1 granted 3 consecutive cycles, then input 3 granted in cycle 4.
4. Locked to input 1 on output 2, out_ready[2]=0 for 2 cycles mid-packet -> no grant those cycles, lock held; resume when ready returns; input 3 never granted before the tail.
5. Parallel non-conflicting traffic: req[0]=0100, req[1]=1000, req[2]=0001, req[3]=0010 -> grant=1111, xbar_select[2][0]=xbar_select[3][1]=xbar_select[0][2]=xbar_select[1][3]=1.
6. Assert rst_n=0 while output 0 is locked to input 2, then release; input 3 requests output 0 with tail=1 -> input 3 granted on the first cycle after reset, with no stale lock.
